// File: rtl/float_calc_pkg.sv
// Shared types and constants for the float_calc request arbiter.
// FLOAT_CALC_ARB_NAN_EN (see float_calc_arbiter) selects the quiet-NaN substitution.
package float_calc_pkg;

  localparam int unsigned DATA_W      = 32;
  localparam int unsigned CNT_W       = 4;
  localparam int unsigned LAT_DEFAULT = 4;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  localparam logic [DATA_W-1:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [1:0]        op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } fc_req_t;

  // Replace the result with a quiet NaN when enabled and the divider flagged an error.
  function automatic logic [DATA_W-1:0] apply_nan(input logic [DATA_W-1:0] data,
                                                  input logic err, input logic en);
    return (en && err) ? QNAN : data;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: pointer names the requester preferred when both request.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       pointer,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = pointer ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/float_calc_arbiter.sv
// Shares one float_calc unit between two requesters with round-robin grant and a fixed settle wait.
// Define FLOAT_CALC_ARB_NAN_EN to return a quiet NaN whenever a divide error is captured.
module float_calc_arbiter
  import float_calc_pkg::*;
#(
  parameter int unsigned LAT = LAT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [1:0]        req0_op,
  input  logic [DATA_W-1:0] req0_A,
  input  logic [DATA_W-1:0] req0_B,
  input  logic              req1_valid,
  input  logic [1:0]        req1_op,
  input  logic [DATA_W-1:0] req1_A,
  input  logic [DATA_W-1:0] req1_B,
  output logic              req0_ready,
  output logic              req1_ready,
  output logic              resp0_valid,
  output logic              resp1_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_ovf,
  output logic              resp_err,
  output logic [DATA_W-1:0] fc_A,
  output logic [DATA_W-1:0] fc_B,
  input  logic [DATA_W-1:0] fc_add,
  input  logic [DATA_W-1:0] fc_sub,
  input  logic [DATA_W-1:0] fc_mul,
  input  logic [DATA_W-1:0] fc_div,
  input  logic [3:0]        fc_overflow,
  input  logic              fc_err
);

`ifdef FLOAT_CALC_ARB_NAN_EN
  localparam logic NAN_EN = 1'b1;
`else
  localparam logic NAN_EN = 1'b0;
`endif

  state_e             state_q, state_d;
  logic               ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic               owner_q, owner_d;
  logic [DATA_W-1:0]  fc_a_q, fc_a_d, fc_b_q, fc_b_d;
  logic [DATA_W-1:0]  resp_data_q, resp_data_d;
  logic               resp_ovf_q, resp_ovf_d, resp_err_q, resp_err_d;
  logic [1:0]         resp_v_q, resp_v_d;

  logic [1:0]         grant;
  logic [1:0]         ready_c;
  logic [1:0]         accept_c;
  fc_req_t            sel_req_c;
  logic [DATA_W-1:0]  result_c;
  logic               err_c;

  rr_arb2 u_rr_arb2 (
    .req     ({req1_valid, req0_valid}),
    .pointer (ptr_q),
    .grant   (grant)
  );

  // Ready is offered only while idle and out of reset.
  assign ready_c  = (state_q == ST_IDLE && !rst) ? grant : 2'b00;
  assign accept_c = ready_c & {req1_valid, req0_valid};

  always_comb begin
    sel_req_c = accept_c[1] ? fc_req_t'{req1_op, req1_A, req1_B}
                            : fc_req_t'{req0_op, req0_A, req0_B};
  end

  always_comb begin
    result_c = fc_div;
    case (op_q)
      OP_ADD:  result_c = fc_add;
      OP_SUB:  result_c = fc_sub;
      OP_MUL:  result_c = fc_mul;
      default: result_c = fc_div;
    endcase
  end

  assign err_c = (op_q == OP_DIV) && fc_err;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    owner_d     = owner_q;
    fc_a_d      = fc_a_q;
    fc_b_d      = fc_b_q;
    resp_data_d = resp_data_q;
    resp_ovf_d  = resp_ovf_q;
    resp_err_d  = resp_err_q;
    resp_v_d    = 2'b00;
    case (state_q)
      ST_IDLE: begin
        if (|accept_c) begin
          op_d    = sel_req_c.op;
          fc_a_d  = sel_req_c.a;
          fc_b_d  = sel_req_c.b;
          owner_d = accept_c[1];
          ptr_d   = ~accept_c[1];
          cnt_d   = CNT_W'(LAT);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          resp_data_d       = apply_nan(result_c, err_c, NAN_EN);
          resp_ovf_d        = fc_overflow[op_q];
          resp_err_d        = err_c;
          resp_v_d[owner_q] = 1'b1;
          state_d           = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= 1'b0;
      cnt_q       <= '0;
      op_q        <= '0;
      owner_q     <= 1'b0;
      fc_a_q      <= '0;
      fc_b_q      <= '0;
      resp_data_q <= '0;
      resp_ovf_q  <= 1'b0;
      resp_err_q  <= 1'b0;
      resp_v_q    <= 2'b00;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      owner_q     <= owner_d;
      fc_a_q      <= fc_a_d;
      fc_b_q      <= fc_b_d;
      resp_data_q <= resp_data_d;
      resp_ovf_q  <= resp_ovf_d;
      resp_err_q  <= resp_err_d;
      resp_v_q    <= resp_v_d;
    end
  end

  assign req0_ready  = ready_c[0];
  assign req1_ready  = ready_c[1];
  assign resp0_valid = resp_v_q[0];
  assign resp1_valid = resp_v_q[1];
  assign resp_data   = resp_data_q;
  assign resp_ovf    = resp_ovf_q;
  assign resp_err    = resp_err_q;
  assign fc_A        = fc_a_q;
  assign fc_B        = fc_b_q;

endmodule

// File: tb/tb_float_calc_arbiter.sv
// Randomized and directed bench for float_calc_arbiter against a timestamp-based transaction model.
module tb_float_calc_arbiter;

  localparam int unsigned TB_LAT = 4;
`ifdef FLOAT_CALC_ARB_NAN_EN
  localparam bit NAN_ON = 1'b1;
`else
  localparam bit NAN_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [1:0]  req0_op = '0, req1_op = '0;
  logic [31:0] req0_A = '0, req0_B = '0, req1_A = '0, req1_B = '0;
  logic        req0_ready, req1_ready, resp0_valid, resp1_valid;
  logic [31:0] resp_data, fc_A, fc_B;
  logic        resp_ovf, resp_err;
  logic [31:0] fc_add = '0, fc_sub = '0, fc_mul = '0, fc_div = '0;
  logic [3:0]  fc_overflow = '0;
  logic        fc_err = 1'b0;

  always #5 clk = ~clk;

  float_calc_arbiter #(.LAT(TB_LAT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_A(req0_A), .req0_B(req0_B),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_A(req1_A), .req1_B(req1_B),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
    .resp_data(resp_data), .resp_ovf(resp_ovf), .resp_err(resp_err),
    .fc_A(fc_A), .fc_B(fc_B),
    .fc_add(fc_add), .fc_sub(fc_sub), .fc_mul(fc_mul), .fc_div(fc_div),
    .fc_overflow(fc_overflow), .fc_err(fc_err)
  );

  int n_checks = 0;
  int n_errors = 0;
  int edge_n   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, edge_n);
    end
  endtask

  // Model: one operation in flight, tracked by its accept edge number.
  bit        m_busy = 0, m_ptr = 0, m_owner = 0, m_ovf = 0, m_err = 0;
  int        m_acc = 0;
  bit [1:0]  m_op = 0, m_pv = 0;
  bit [31:0] m_a = 0, m_b = 0, m_data = 0;

  function automatic int winner(input logic v0, input logic v1, input bit p);
    if (v0 && v1) return p ? 1 : 0;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  initial forever begin
    int w;
    @(posedge clk);
    edge_n++;
    m_pv = 2'b00;
    if (rst) begin
      m_busy = 0; m_ptr = 0; m_a = 0; m_b = 0; m_data = 0; m_ovf = 0; m_err = 0;
    end else if (m_busy) begin
      if (edge_n == m_acc + int'(TB_LAT)) begin
        case (m_op)
          2'd0:    m_data = fc_add;
          2'd1:    m_data = fc_sub;
          2'd2:    m_data = fc_mul;
          default: m_data = fc_div;
        endcase
        m_ovf = fc_overflow[m_op];
        m_err = (m_op == 2'd3) && fc_err;
        if (NAN_ON && m_err) m_data = 32'h7FC00000;
        m_pv[m_owner] = 1'b1;
      end else if (edge_n == m_acc + int'(TB_LAT) + 1) begin
        m_busy = 0;
      end
    end else begin
      w = winner(req0_valid, req1_valid, m_ptr);
      if (w >= 0) begin
        m_busy  = 1;
        m_acc   = edge_n;
        m_owner = (w == 1);
        m_ptr   = (w == 0);
        m_op    = (w == 1) ? req1_op : req0_op;
        m_a     = (w == 1) ? req1_A : req0_A;
        m_b     = (w == 1) ? req1_B : req0_B;
      end
    end
  end

  // Event logs for directed scenarios.
  int          acc_c[$], acc_w[$], pl_c[$], pl_w[$];
  logic [31:0] pl_d[$];
  logic        pl_o[$], pl_e[$];

  initial forever begin
    int w;
    @(negedge clk);
    if (edge_n > 0) begin
      w = winner(req0_valid, req1_valid, m_ptr);
      chk("req0_ready", 32'(req0_ready), 32'(!m_busy && !rst && w == 0));
      chk("req1_ready", 32'(req1_ready), 32'(!m_busy && !rst && w == 1));
      chk("resp0_valid", 32'(resp0_valid), 32'(m_pv[0]));
      chk("resp1_valid", 32'(resp1_valid), 32'(m_pv[1]));
      chk("resp_data", resp_data, m_data);
      chk("resp_ovf", 32'(resp_ovf), 32'(m_ovf));
      chk("resp_err", 32'(resp_err), 32'(m_err));
      chk("fc_A", fc_A, m_a);
      chk("fc_B", fc_B, m_b);
      if (req0_ready && req0_valid) begin acc_c.push_back(edge_n); acc_w.push_back(0); end
      if (req1_ready && req1_valid) begin acc_c.push_back(edge_n); acc_w.push_back(1); end
      if (resp0_valid || resp1_valid) begin
        pl_c.push_back(edge_n); pl_w.push_back(resp1_valid ? 1 : 0);
        pl_d.push_back(resp_data); pl_o.push_back(resp_ovf); pl_e.push_back(resp_err);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    acc_c.delete(); acc_w.delete(); pl_c.delete(); pl_w.delete();
    pl_d.delete(); pl_o.delete(); pl_e.delete();
  endtask

  task automatic wait_accepts(input int n, input string name);
    for (int i = 0; i < 40 && acc_c.size() < n; i++) step();
    chk(name, 32'(acc_c.size()), 32'(n));
  endtask

  task automatic wait_pulses(input int n, input string name);
    for (int i = 0; i < 40 && pl_c.size() < n; i++) step();
    chk(name, 32'(pl_c.size()), 32'(n));
  endtask

  initial begin
    int c0;
    repeat (3) step();
    chk("rst_fc_A", fc_A, 32'h0);
    chk("rst_resp_data", resp_data, 32'h0);
    chk("rst_resp_valid", 32'({resp1_valid, resp0_valid}), 32'h0);
    rst = 1'b0;
    step();

    // Single add from requester 0.
    clear_logs();
    fc_add = 32'h40400000; fc_overflow = 4'b0000; fc_err = 1'b0;
    req0_op = 2'd0; req0_A = 32'h3F800000; req0_B = 32'h40000000; req0_valid = 1'b1;
    wait_accepts(1, "add_accept");
    req0_valid = 1'b0;
    wait_pulses(1, "add_pulse");
    if (pl_c.size() >= 1 && acc_c.size() >= 1) begin
      chk("add_who", 32'(pl_w[0]), 32'd0);
      chk("add_data", pl_d[0], 32'h40400000);
      chk("add_ovf", 32'(pl_o[0]), 32'd0);
      chk("add_latency", 32'(pl_c[0] - acc_c[0]), 32'(TB_LAT + 1));
      chk("add_fc_A_held", fc_A, 32'h3F800000);
    end

    // Mul from requester 1; overflow bit 2 clear, divider error ignored for mul.
    clear_logs();
    fc_mul = 32'h40C00000; fc_overflow = 4'b1011; fc_err = 1'b1;
    req1_op = 2'd2; req1_A = 32'h40000000; req1_B = 32'h40400000; req1_valid = 1'b1;
    wait_accepts(1, "mul_accept");
    req1_valid = 1'b0;
    wait_pulses(1, "mul_pulse");
    repeat (4) step();
    chk("mul_pulse_count", 32'(pl_c.size()), 32'd1);
    if (pl_c.size() >= 1) begin
      chk("mul_who", 32'(pl_w[0]), 32'd1);
      chk("mul_data", pl_d[0], 32'h40C00000);
      chk("mul_ovf", 32'(pl_o[0]), 32'd0);
      chk("mul_err", 32'(pl_e[0]), 32'd0);
    end
    fc_overflow = 4'b0000; fc_err = 1'b0;

    // Both valid straight out of reset.
    rst = 1'b1;
    fc_sub = 32'h40000000; fc_add = 32'h40400000;
    req0_op = 2'd1; req0_A = 32'h40400000; req0_B = 32'h3F800000; req0_valid = 1'b1;
    req1_op = 2'd0; req1_A = 32'h3F800000; req1_B = 32'h40000000; req1_valid = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    clear_logs();
    c0 = edge_n;
    wait_accepts(1, "both_first_accept");
    req0_valid = 1'b0;
    wait_accepts(2, "both_second_accept");
    req1_valid = 1'b0;
    wait_pulses(2, "both_pulses");
    if (acc_c.size() >= 2 && pl_c.size() >= 2) begin
      chk("both_first_who", 32'(acc_w[0]), 32'd0);
      chk("both_first_cycle", 32'(acc_c[0]), 32'(c0));
      chk("both_second_who", 32'(acc_w[1]), 32'd1);
      chk("both_second_cycle", 32'(acc_c[1]), 32'(pl_c[0] + 1));
      chk("both_resp0_data", pl_d[0], 32'h40000000);
      chk("both_resp1_who", 32'(pl_w[1]), 32'd1);
      chk("both_resp1_data", pl_d[1], 32'h40400000);
    end

    // Divide by zero with divider error.
    clear_logs();
    fc_div = 32'h7F800000; fc_err = 1'b1; fc_overflow = 4'b1000;
    req0_op = 2'd3; req0_A = 32'h3F800000; req0_B = 32'h00000000; req0_valid = 1'b1;
    wait_accepts(1, "div_accept");
    req0_valid = 1'b0;
    wait_pulses(1, "div_pulse");
    if (pl_c.size() >= 1) begin
      chk("div_err", 32'(pl_e[0]), 32'd1);
      chk("div_ovf", 32'(pl_o[0]), 32'd1);
      chk("div_data", pl_d[0], NAN_ON ? 32'h7FC00000 : 32'h7F800000);
    end
    fc_err = 1'b0; fc_overflow = 4'b0000;

    // Reset two cycles into an operation; pointer must restart at requester 0.
    clear_logs();
    req0_op = 2'd0; req0_valid = 1'b1;
    wait_accepts(1, "abort_accept");
    req0_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_fc_A", fc_A, 32'h0);
    chk("abort_fc_B", fc_B, 32'h0);
    chk("abort_resp_data", resp_data, 32'h0);
    chk("abort_resp_err", 32'(resp_err), 32'd0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    wait_accepts(2, "post_abort_accept");
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_pulses(1, "post_abort_pulse");
    repeat (8) step();
    chk("abort_pulse_count", 32'(pl_c.size()), 32'd1);
    if (acc_c.size() >= 2 && pl_c.size() >= 1) begin
      chk("post_abort_who", 32'(acc_w[1]), 32'd0);
      chk("post_abort_latency", 32'(pl_c[0] - acc_c[1]), 32'(TB_LAT + 1));
    end

    // Requester 1 withdraws during requester 0's wait.
    clear_logs();
    req0_valid = 1'b1;
    wait_accepts(1, "drop_accept");
    req0_valid = 1'b0;
    req1_valid = 1'b1;
    repeat (2) step();
    req1_valid = 1'b0;
    wait_pulses(1, "drop_pulse");
    repeat (10) step();
    chk("drop_accept_count", 32'(acc_c.size()), 32'd1);
    chk("drop_pulse_count", 32'(pl_c.size()), 32'd1);
    if (pl_c.size() >= 1) chk("drop_who", 32'(pl_w[0]), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 255) == 0);
      req0_valid  = ($urandom_range(0, 2) != 0);
      req1_valid  = ($urandom_range(0, 2) != 0);
      req0_op     = 2'($urandom_range(0, 3));
      req1_op     = 2'($urandom_range(0, 3));
      req0_A      = $urandom; req0_B = $urandom;
      req1_A      = $urandom; req1_B = $urandom;
      fc_add      = $urandom; fc_sub = $urandom;
      fc_mul      = $urandom; fc_div = $urandom;
      fc_overflow = 4'($urandom_range(0, 15));
      fc_err      = 1'($urandom_range(0, 1));
      step();
    end
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/float_calc_arbiter.md
FLOAT_CALC_ARBITER -- requirements
Module: float_calc_arbiter

Interface
REQ-001 Parameter LAT, default 4, SHALL set the float_calc result-settle wait in clk cycles; legal range 1..15.
REQ-002 clk  in  1  SHALL be the single rising-edge clock.
REQ-003 rst  in  1  SHALL be a synchronous, active-high reset.
REQ-004 req0_valid / req1_valid  in  1  SHALL mark that a requester holds a pending operation.
REQ-005 req0_op / req1_op  in  2  SHALL encode the operation: 00 add, 01 sub, 10 mul, 11 div.
REQ-006 req0_A, req0_B / req1_A, req1_B  in  32  SHALL carry IEEE-754 single-precision operands.
REQ-007 req0_ready / req1_ready  out  1  SHALL signal acceptance; transfer occurs on the edge where valid and ready are both high.
REQ-008 resp0_valid / resp1_valid  out  1  SHALL be a one-cycle pulse marking the response to that requester.
REQ-009 resp_data  out  32, resp_ovf  out  1, resp_err  out  1  SHALL carry the shared response payload.
REQ-010 fc_A, fc_B  out  32  SHALL drive the float_calc operand inputs.
REQ-011 fc_add, fc_sub, fc_mul, fc_div  in  32, fc_overflow  in  4, fc_err  in  1  SHALL receive the float_calc outputs.

Function
REQ-012 The FSM SHALL have states IDLE, WAIT and DONE.
REQ-013 In IDLE, reqN_ready SHALL be high only for the granted requester, and both SHALL be low in WAIT and DONE.
REQ-014 Grant SHALL be round-robin: a single valid requester is granted; when both are valid, the one not accepted last is granted.
REQ-015 The round-robin pointer SHALL update only on an accept.
REQ-016 On accept, the block SHALL register op, fc_A <= reqN_A, fc_B <= reqN_B and the owner index, load the wait counter with LAT, and go to WAIT.
REQ-017 WAIT SHALL decrement the counter each cycle.
REQ-018 At counter = 1, WAIT SHALL capture the result selected by op into resp_data and go to DONE.
REQ-019 The captured resp_ovf SHALL be fc_overflow[op], with bit order add=0, sub=1, mul=2, div=3.
REQ-020 The captured resp_err SHALL be fc_err when op = div, else 0.
REQ-021 DONE SHALL assert resp{owner}_valid for exactly one cycle, then return to IDLE.
REQ-022 Latency SHALL be: accept at edge k, capture at edge k+LAT, response pulse in the cycle after edge k+LAT; throughput SHALL be one op per LAT+2 cycles.
REQ-023 fc_A, fc_B and resp_* SHALL hold their values until the next accept or capture, respectively.
REQ-024 A requester SHALL be allowed to drop valid before accept with no effect; requests arriving in WAIT or DONE SHALL stall until IDLE.
REQ-025 Both requesters becoming valid in the same cycle SHALL resolve by the pointer, with no loss of either request.

Reset
REQ-026 Reset SHALL force state IDLE, pointer to requester 0, counter 0, and all outputs to 0.
REQ-027 Reset during WAIT or DONE SHALL abort the operation with no response pulse.

Configuration
REQ-028 With macro FLOAT_CALC_ARB_NAN_EN defined, a captured resp_err = 1 SHALL force resp_data to 32'h7FC00000 (quiet NaN).
REQ-029 Without FLOAT_CALC_ARB_NAN_EN, fc_div SHALL pass unmodified on error.

Structure
REQ-030 Shared package float_calc_pkg SHALL hold the op-code constants, the FSM state enum, the NaN constant and the LAT default.
REQ-031 The two-way round-robin grant SHALL be a sub-module rr_arb2 (inputs: req[1:0], pointer; output: one-hot grant).

Verification
REQ-032 req0 add 3F800000 + 40000000, LAT=4 -> req0_ready at accept, resp0_valid 5 cycles after accept, resp_data 40400000, resp_ovf 0.
REQ-033 req1 mul 40000000 * 40400000 -> resp1_valid pulse, resp_data 40C00000, and resp0_valid stays 0.
REQ-034 req0 and req1 both valid from reset (sub, add) -> req0 served first, req1 accepted in the first IDLE cycle after req0's response, and outputs in order.
REQ-035 req0 div 3F800000 / 00000000 with fc_err=1 -> resp_err 1; resp_data 7FC00000 with FLOAT_CALC_ARB_NAN_EN defined, else raw fc_div.
REQ-036 rst pulsed 2 cycles after an accept -> no resp pulse, all outputs 0, and the next request is granted to req0.
REQ-037 req1 valid dropped during req0's WAIT -> req1 never accepted and no resp1_valid.
